// File: rtl/fft_ctrl_pkg.sv
// Shared types and legacy timing constants
// for the FFT stage control blocks.
package fft_ctrl_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ctrl_state_e;

    localparam int FAC8_PERIOD = 16;
    localparam int FAC8_VSTART = 8;
    localparam int FAC8_VEND   = 15;

endpackage

// File: rtl/ctrl_fft_valid_win.sv
// Frame counter with a registered valid window
// for the FFT stage and twiddle datapaths.
module ctrl_fft_valid_win
    import fft_ctrl_pkg::*;
#(
    parameter  int PERIOD      = FAC8_PERIOD,
    parameter  int VALID_START = FAC8_VSTART,
    parameter  int VALID_END   = FAC8_VEND,
    parameter  int FRM_WIDTH   = 8,
    localparam int CNT_WIDTH   = $clog2(PERIOD)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [FRM_WIDTH-1:0] num_frames,
    input  logic                 abort,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 valid_o,
    output logic [CNT_WIDTH-1:0] valid_idx,
    output logic [FRM_WIDTH-1:0] frame_idx,
    output logic                 frame_done
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [FRM_WIDTH-1:0] FRM_ONE  = FRM_WIDTH'(1);
    localparam logic [31:0]          VS32     = 32'(VALID_START);
    localparam logic [31:0]          VE32     = 32'(VALID_END);

    if (PERIOD < 2) begin : g_bad_period
        $error("ctrl_fft_valid_win: PERIOD must be >= 2");
    end
    if (VALID_START < 0 || VALID_START > VALID_END) begin : g_bad_start
        $error("ctrl_fft_valid_win: need 0 <= VALID_START <= VALID_END");
    end
    if (VALID_END >= PERIOD) begin : g_bad_end
        $error("ctrl_fft_valid_win: need VALID_END < PERIOD");
    end
    if (FRM_WIDTH < 1) begin : g_bad_frm
        $error("ctrl_fft_valid_win: FRM_WIDTH must be >= 1");
    end

    ctrl_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [FRM_WIDTH-1:0]   frm_q, frm_d;
    logic [FRM_WIDTH-1:0]   nfr_q, nfr_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   vidx_q, vidx_d;
    logic                   done_q, done_d;
    logic                   last_frm;
    logic [31:0]            cnt_ext;

    // Count zero means free-run, so it never matches as the last frame.
    assign last_frm = (nfr_q != '0) && (frm_q == nfr_q - FRM_ONE);

    // Next state and counters; abort overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frm_d   = frm_q;
        nfr_d   = nfr_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            frm_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        frm_d   = '0;
                        nfr_d   = num_frames;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (last_frm) begin
                            frm_d = '0;
                            if (en) begin
                                nfr_d = num_frames;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            frm_d = frm_q + FRM_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Strobes derive from the next count so they line up with cnt_o.
    always_comb begin
        cnt_ext = 32'(cnt_d);
        valid_d = (state_d == ST_RUN) && (cnt_ext >= VS32) && (cnt_ext <= VE32);
        vidx_d  = valid_d ? CNT_WIDTH'(cnt_ext - VS32) : '0;
        done_d  = (state_d == ST_RUN) && (cnt_d == CNT_LAST);
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            frm_q   <= '0;
            nfr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
            nfr_q   <= nfr_d;
        end
    end

    // Registered window strobe, index and frame-end pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            vidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            vidx_q  <= vidx_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign cnt_o      = cnt_q;
    assign frame_idx  = frm_q;
    assign valid_o    = valid_q;
    assign valid_idx  = vidx_q;
    assign frame_done = done_q;

endmodule
